// File: rtl/goertzel_bank.sv
// Four parallel Goertzel bins over a signed sample stream, emitting 64-bit bin powers per block.
// Latency: 2 cycles from the last accepted sample of a block to the advance strobe.
// Backpressure: none; a sample is accepted on every sample_valid cycle and state holds otherwise.
module goertzel_bank #(
   parameter int SAMPLE_WIDTH = 16,
   parameter int BLOCK_LEN    = 256,
   parameter int COEFF_1      = 31785,
   parameter int COEFF_2      = 28899,
   parameter int COEFF_3      = 24279,
   parameter int COEFF_4      = 18205
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           sample_valid,
   input  logic signed [SAMPLE_WIDTH-1:0] sample,
   output logic signed [63:0]             power_1,
   output logic signed [63:0]             power_2,
   output logic signed [63:0]             power_3,
   output logic signed [63:0]             power_4,
   output logic                           advance
);

   // Q2.14 coefficients, one per bin
   localparam logic signed [17:0] COEFF [4] = '{18'(COEFF_1), 18'(COEFF_2), 18'(COEFF_3), 18'(COEFF_4)};
   localparam logic [15:0]        LAST_IDX  = 16'(BLOCK_LEN - 1);

   // (coeff * s) >>> 14 on the full 50-bit product, then truncated to 32 bits
   function automatic logic signed [31:0] coeff_mul(input logic signed [17:0] c,
                                                    input logic signed [31:0] s);
      logic signed [49:0] prod;
      prod = 50'(c) * 50'(s);
      return 32'(prod >>> 14);
   endfunction

   logic signed [31:0] x_ext;
   logic signed [31:0] s1 [4];
   logic signed [31:0] s2 [4];
   logic signed [31:0] s_new [4];
   logic signed [31:0] snap1 [4];
   logic signed [31:0] snap2 [4];
   logic signed [63:0] a_q [4];
   logic signed [63:0] b_q [4];
   logic signed [63:0] c_q [4];
   logic signed [63:0] pwr [4];
   logic [15:0]        count;
   logic               blk_last;
   logic               snap_vld;
   logic               stg1_vld;

   assign x_ext    = 32'(sample);
   assign blk_last = sample_valid && (count == LAST_IDX);

   // One Goertzel step per bin for the sample currently presented
   always_comb begin
      for (int b = 0; b < 4; b++) begin
         s_new[b] = x_ext + coeff_mul(COEFF[b], s1[b]) - s2[b];
      end
   end

   // Recurrence state and sample counter; the last sample of a block restarts both
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
         for (int b = 0; b < 4; b++) begin
            s1[b] <= '0;
            s2[b] <= '0;
         end
      end else if (sample_valid) begin
         if (blk_last) begin
            count <= '0;
            for (int b = 0; b < 4; b++) begin
               s1[b] <= '0;
               s2[b] <= '0;
            end
         end else begin
            count <= count + 16'd1;
            for (int b = 0; b < 4; b++) begin
               s1[b] <= s_new[b];
               s2[b] <= s1[b];
            end
         end
      end
   end

   // Capture the post-update state of the final sample so the recurrence can restart at once
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         snap_vld <= 1'b0;
         for (int b = 0; b < 4; b++) begin
            snap1[b] <= '0;
            snap2[b] <= '0;
         end
      end else begin
         snap_vld <= blk_last;
         if (blk_last) begin
            for (int b = 0; b < 4; b++) begin
               snap1[b] <= s_new[b];
               snap2[b] <= s1[b];
            end
         end
      end
   end

   // Power stage 1: the three product terms
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stg1_vld <= 1'b0;
         for (int b = 0; b < 4; b++) begin
            a_q[b] <= '0;
            b_q[b] <= '0;
            c_q[b] <= '0;
         end
      end else begin
         stg1_vld <= snap_vld;
         if (snap_vld) begin
            for (int b = 0; b < 4; b++) begin
               a_q[b] <= 64'(snap1[b]) * 64'(snap1[b]);
               b_q[b] <= 64'(snap2[b]) * 64'(snap2[b]);
               c_q[b] <= 64'(coeff_mul(COEFF[b], snap1[b])) * 64'(snap2[b]);
            end
         end
      end
   end

   // Power stage 2: combine terms, hold result until the next block, strobe advance
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         advance <= 1'b0;
         for (int b = 0; b < 4; b++) begin
            pwr[b] <= '0;
         end
      end else begin
         advance <= stg1_vld;
         if (stg1_vld) begin
            for (int b = 0; b < 4; b++) begin
               pwr[b] <= a_q[b] + b_q[b] - c_q[b];
            end
         end
      end
   end

   assign power_1 = pwr[0];
   assign power_2 = pwr[1];
   assign power_3 = pwr[2];
   assign power_4 = pwr[3];

endmodule

// File: tb/tb_goertzel_bank.sv
// Bench for goertzel_bank: table-driven tone vectors, randomized blocks against a block-level model,
// and hand-written reset sequences.
module tb_goertzel_bank;
   localparam int BL = 4;
   localparam int CO [4] = '{32768, 0, -32768, 18205};

   logic               clk = 1'b0;
   logic               reset;
   logic               sample_valid;
   logic signed [15:0] sample;
   logic signed [63:0] power_1, power_2, power_3, power_4;
   logic               advance;

   goertzel_bank #(
      .SAMPLE_WIDTH(16),
      .BLOCK_LEN   (BL),
      .COEFF_1     (CO[0]),
      .COEFF_2     (CO[1]),
      .COEFF_3     (CO[2]),
      .COEFF_4     (CO[3])
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .sample_valid(sample_valid),
      .sample      (sample),
      .power_1     (power_1),
      .power_2     (power_2),
      .power_3     (power_3),
      .power_4     (power_4),
      .advance     (advance)
   );

   always #5 clk = ~clk;

   typedef struct { longint p [4]; } pw_t;
   typedef struct {
      string  name;
      int     xs [BL];
      longint e1;
      longint e2;
      longint e3;
   } vec_t;

   int  checks  = 0;
   int  errors  = 0;
   int  adv_cnt = 0;
   pw_t pq [$];

   // Record every advance strobe and the powers presented with it
   always @(negedge clk) begin : mon
      pw_t t;
      if (advance) begin
         adv_cnt++;
         t.p[0] = power_1;
         t.p[1] = power_2;
         t.p[2] = power_3;
         t.p[3] = power_4;
         pq.push_back(t);
      end
   end

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Block-level power computed straight from the filter definition
   function automatic pw_t model_block(input int xs [BL]);
      pw_t r;
      for (int b = 0; b < 4; b++) begin
         int s1, s2, s, pk;
         s1 = 0;
         s2 = 0;
         for (int n = 0; n < BL; n++) begin
            s  = xs[n] + int'((longint'(CO[b]) * longint'(s1)) >>> 14) - s2;
            s2 = s1;
            s1 = s;
         end
         pk     = int'((longint'(CO[b]) * longint'(s1)) >>> 14);
         r.p[b] = longint'(s1) * longint'(s1) + longint'(s2) * longint'(s2) - longint'(pk) * longint'(s2);
      end
      return r;
   endfunction

   task automatic feed(input int xs [$], input bit gaps);
      foreach (xs[i]) begin
         if (gaps) repeat ($urandom_range(0, 3)) step();
         sample_valid = 1'b1;
         sample       = 16'(xs[i]);
         step();
         sample_valid = 1'b0;
      end
   endtask

   task automatic check_blocks(input string name, input int xs [$], input int nblk);
      for (int k = 0; k < nblk; k++) begin
         int  blk [BL];
         pw_t e;
         for (int n = 0; n < BL; n++) blk[n] = xs[k * BL + n];
         e = model_block(blk);
         if (k < pq.size()) begin
            for (int b = 0; b < 4; b++) begin
               check($sformatf("%s blk%0d bin%0d", name, k, b + 1), pq[k].p[b], e.p[b]);
            end
         end
      end
   endtask

   task automatic run_random(input string name, input int nblk, input bit gaps);
      int xs [$];
      int a0;
      for (int i = 0; i < nblk * BL; i++) xs.push_back(int'($urandom_range(0, 65535)) - 32768);
      pq.delete();
      a0 = adv_cnt;
      feed(xs, gaps);
      repeat (4) step();
      check({name, " advance count"}, longint'(adv_cnt - a0), longint'(nblk));
      check_blocks(name, xs, nblk);
   endtask

   task automatic async_reset_pulse();
      @(posedge clk);
      #3 reset = 1'b1;
      #1;
      @(posedge clk);
      #1 reset = 1'b0;
   endtask

   vec_t vt [4];

   initial begin
      reset        = 1'b1;
      sample_valid = 1'b0;
      sample       = '0;
      vt[0] = '{"dc",      '{1000, 1000, 1000, 1000},   64'sd16000000, 64'sd0,       64'sd0};
      vt[1] = '{"quarter", '{1000, 0, -1000, 0},        64'sd0,        64'sd4000000, 64'sd0};
      vt[2] = '{"nyquist", '{1000, -1000, 1000, -1000}, 64'sd0,        64'sd0,       64'sd16000000};
      vt[3] = '{"zero",    '{0, 0, 0, 0},               64'sd0,        64'sd0,       64'sd0};

      repeat (3) step();
      check("reset power_1", power_1, 64'sd0);
      check("reset power_4", power_4, 64'sd0);
      check("reset advance", longint'(advance), 64'sd0);
      reset = 1'b0;
      step();

      // Table-driven tone vectors with exact strobe timing
      for (int v = 0; v < 4; v++) begin
         int  q [$];
         pw_t e;
         e = model_block(vt[v].xs);
         for (int k = 0; k < BL; k++) q.push_back(vt[v].xs[k]);
         feed(q, 1'b0);
         step();
         check({vt[v].name, " advance t+1"}, longint'(advance), 64'sd0);
         step();
         check({vt[v].name, " advance t+2"}, longint'(advance), 64'sd1);
         check({vt[v].name, " power_1"}, power_1, vt[v].e1);
         check({vt[v].name, " power_2"}, power_2, vt[v].e2);
         check({vt[v].name, " power_3"}, power_3, vt[v].e3);
         check({vt[v].name, " power_4"}, power_4, e.p[3]);
         step();
         check({vt[v].name, " advance t+3"}, longint'(advance), 64'sd0);
         check({vt[v].name, " power_1 held"}, power_1, vt[v].e1);
      end

      // Back-to-back blocks, then the same kind of traffic with random gaps
      run_random("b2b", 3, 1'b0);
      run_random("gaps", 3, 1'b1);
      run_random("long", 15, 1'b1);

      // Asynchronous reset mid-cycle clears outputs immediately
      begin
         int a0;
         @(posedge clk);
         #3 reset = 1'b1;
         #1;
         check("async reset power_1", power_1, 64'sd0);
         check("async reset power_2", power_2, 64'sd0);
         check("async reset power_3", power_3, 64'sd0);
         check("async reset power_4", power_4, 64'sd0);
         check("async reset advance", longint'(advance), 64'sd0);
         @(posedge clk);
         #1 reset = 1'b0;
         a0 = adv_cnt;
         repeat (10) step();
         check("idle after reset advances", longint'(adv_cnt - a0), 64'sd0);
      end

      // Reset after half a block, then a full DC block
      begin
         int a0;
         int h [$];
         int d [$];
         h = '{1000, 1000};
         d = '{1000, 1000, 1000, 1000};
         a0 = adv_cnt;
         feed(h, 1'b0);
         async_reset_pulse();
         feed(d, 1'b0);
         repeat (4) step();
         check("mid-block reset advance count", longint'(adv_cnt - a0), 64'sd1);
         check("mid-block reset power_1", power_1, 64'sd16000000);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
